ranc_output_collector: RTL and testbench

Downstream consumer of the RANC network grid output port. Captures the neuron-index packets emitted on `packet_out`/`packet_out_valid` during each tick frame, builds a deduplicated spike vector and per-class spike counts, and at each `tick` snapshots the frame and runs a sequential argmax to report the winning class. It replaces bench-side spike logging and is synthesizable for on-chip classification readout.

---
 rtl/ranc_output_collector.sv | 163 ++++++++++++++++
 tb/tb_ranc_output_collector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ranc_output_collector.sv
// Collects neuron-index spikes from the RANC grid output per tick frame, snapshots
// them at each tick and runs a one-class-per-cycle argmax to report the winning class.
module ranc_output_collector #(
  parameter  int NUM_CLASSES    = 10,
  parameter  int GROUP_SIZE     = 25,
  parameter  int IDX_WIDTH      = 8,
  parameter  int DISCARD_FRAMES = 1,
  localparam int NUM_OUTPUT     = NUM_CLASSES * GROUP_SIZE,
  localparam int CLS_W          = $clog2(NUM_CLASSES),
  localparam int COUNT_W        = $clog2(GROUP_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [IDX_WIDTH-1:0]  packet_out,
  input  logic                  packet_out_valid,
  output logic [NUM_OUTPUT-1:0] spike_vector,
  output logic [CLS_W-1:0]      class_out,
  output logic [COUNT_W-1:0]    class_count,
  output logic                  result_valid,
  output logic [15:0]           frame_count,
  output logic                  overrun_error,
  output logic                  range_error
);

  localparam int          VEC_AW    = $clog2(NUM_OUTPUT);
  localparam logic [15:0] DISCARD_N = 16'(DISCARD_FRAMES);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {COLLECT, SCAN, REPORT} state_e;

  state_e                state_q, state_d;
  logic [NUM_OUTPUT-1:0] live_vec_q, live_vec_d;
  logic [COUNT_W-1:0]    live_cnt_q [NUM_CLASSES];
  logic [COUNT_W-1:0]    live_cnt_d [NUM_CLASSES];
  logic [COUNT_W-1:0]    snap_cnt_q [NUM_CLASSES];
  logic [COUNT_W-1:0]    snap_cnt_d [NUM_CLASSES];
  logic [NUM_OUTPUT-1:0] spike_vector_q, spike_vector_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [CLS_W-1:0]      k_q, k_d;
  logic [CLS_W-1:0]      best_cls_q, best_cls_d;
  logic [COUNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic [CLS_W-1:0]      class_out_q, class_out_d;
  logic [COUNT_W-1:0]    class_count_q, class_count_d;
  logic                  result_valid_q, result_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  range_q, range_d;

  logic [31:0]           pkt_idx;
  logic [CLS_W-1:0]      pkt_cls;
  logic [VEC_AW-1:0]     pkt_bit;

  always_comb begin
    state_d        = state_q;
    live_vec_d     = live_vec_q;
    live_cnt_d     = live_cnt_q;
    snap_cnt_d     = snap_cnt_q;
    spike_vector_d = spike_vector_q;
    frame_count_d  = frame_count_q;
    k_d            = k_q;
    best_cls_d     = best_cls_q;
    best_cnt_d     = best_cnt_q;
    class_out_d    = class_out_q;
    class_count_d  = class_count_q;
    result_valid_d = 1'b0;
    overrun_d      = overrun_q;
    range_d        = range_q;
    pkt_idx        = 32'(packet_out);
    pkt_cls        = CLS_W'(pkt_idx / GROUP_SIZE);
    pkt_bit        = VEC_AW'(pkt_idx);

    if (tick) begin
      // A tick preempts any scan or report in flight; that result is lost.
      spike_vector_d = live_vec_q;
      snap_cnt_d     = live_cnt_q;
      live_vec_d     = '0;
      live_cnt_d     = '{default: '0};
      if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
      if (state_q != COLLECT) overrun_d = 1'b1;
      if (frame_count_q >= DISCARD_N) begin
        state_d    = SCAN;
        k_d        = '0;
        best_cls_d = '0;
        best_cnt_d = '0;
      end else begin
        state_d = COLLECT;
      end
    end else begin
      case (state_q)
        SCAN: begin
          if (snap_cnt_q[k_q] > best_cnt_q) begin
            best_cls_d = k_q;
            best_cnt_d = snap_cnt_q[k_q];
          end
          if (k_q == LAST_CLS) state_d = REPORT;
          else                 k_d     = k_q + CLS_W'(1);
        end
        REPORT: begin
          class_out_d    = best_cls_q;
          class_count_d  = best_cnt_q;
          result_valid_d = 1'b1;
          state_d        = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end

    // Packets land on the post-tick (cleared) live state when both arrive together.
    if (packet_out_valid) begin
      if (pkt_idx < NUM_OUTPUT) begin
        if (!live_vec_d[pkt_bit]) begin
          live_vec_d[pkt_bit] = 1'b1;
          live_cnt_d[pkt_cls] = live_cnt_d[pkt_cls] + COUNT_W'(1);
        end
      end else begin
        range_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= COLLECT;
      live_vec_q     <= '0;
      live_cnt_q     <= '{default: '0};
      snap_cnt_q     <= '{default: '0};
      spike_vector_q <= '0;
      frame_count_q  <= '0;
      k_q            <= '0;
      best_cls_q     <= '0;
      best_cnt_q     <= '0;
      class_out_q    <= '0;
      class_count_q  <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      range_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      live_vec_q     <= live_vec_d;
      live_cnt_q     <= live_cnt_d;
      snap_cnt_q     <= snap_cnt_d;
      spike_vector_q <= spike_vector_d;
      frame_count_q  <= frame_count_d;
      k_q            <= k_d;
      best_cls_q     <= best_cls_d;
      best_cnt_q     <= best_cnt_d;
      class_out_q    <= class_out_d;
      class_count_q  <= class_count_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      range_q        <= range_d;
    end
  end

  assign spike_vector  = spike_vector_q;
  assign class_out     = class_out_q;
  assign class_count   = class_count_q;
  assign result_valid  = result_valid_q;
  assign frame_count   = frame_count_q;
  assign overrun_error = overrun_q;
  assign range_error   = range_q;

endmodule

// File: tb/tb_ranc_output_collector.sv
// Bench for ranc_output_collector: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ranc_output_collector;

  localparam int NC = 10;
  localparam int GS = 25;
  localparam int NO = NC * GS;
  localparam int LAT = NC + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic [7:0]    packet_out = '0;
  logic          packet_out_valid = 1'b0;
  logic [NO-1:0] spike_vector;
  logic [3:0]    class_out;
  logic [4:0]    class_count;
  logic          result_valid;
  logic [15:0]   frame_count;
  logic          overrun_error;
  logic          range_error;

  ranc_output_collector dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .spike_vector(spike_vector), .class_out(class_out), .class_count(class_count),
    .result_valid(result_valid), .frame_count(frame_count),
    .overrun_error(overrun_error), .range_error(range_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int rv_seen = 0;

  // Reference model state, at frame/transaction level.
  bit [NO-1:0] m_live, m_spk;
  int m_fc, m_cls, m_cnt;
  bit m_ovr, m_rng, m_rv;
  bit pend;
  int pdue, pcls, pcnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit t, input bit v, input int n);
    int cnt, best, bcls;
    if (!rn) begin
      m_live = '0; m_spk = '0; m_fc = 0; m_cls = 0; m_cnt = 0;
      m_ovr = 0; m_rng = 0; m_rv = 0; pend = 0;
      return;
    end
    m_rv = 0;
    if (pend && pdue == cyc_n && !t) begin
      m_rv = 1; m_cls = pcls; m_cnt = pcnt; pend = 0;
    end
    if (t) begin
      if (pend) begin m_ovr = 1; pend = 0; end
      m_spk = m_live;
      if (m_fc >= 1) begin
        best = 0; bcls = 0;
        for (int c = 0; c < NC; c++) begin
          cnt = 0;
          for (int g = 0; g < GS; g++) cnt += m_live[c*GS+g];
          if (cnt > best) begin best = cnt; bcls = c; end
        end
        pend = 1; pdue = cyc_n + LAT; pcls = bcls; pcnt = best;
      end
      if (m_fc < 16'hFFFF) m_fc++;
      m_live = '0;
    end
    if (v) begin
      if (n < NO) m_live[n] = 1'b1;
      else        m_rng = 1'b1;
    end
  endtask

  task automatic cyc(input bit t, input bit v, input int n, input bit rn = 1'b1);
    reset_n = rn; tick = t; packet_out_valid = v; packet_out = 8'(n);
    model_step(rn, t, v, n);
    @(posedge clk);
    #1;
    chk("spike_vector", 256'(spike_vector), 256'(m_spk));
    chk("class_out", 256'(class_out), 256'(m_cls));
    chk("class_count", 256'(class_count), 256'(m_cnt));
    chk("result_valid", 256'(result_valid), 256'(m_rv));
    chk("frame_count", 256'(frame_count), 256'(m_fc));
    chk("overrun_error", 256'(overrun_error), 256'(m_ovr));
    chk("range_error", 256'(range_error), 256'(m_rng));
    if (result_valid === 1'b1) rv_seen++;
    cyc_n++;
    tick = 0; packet_out_valid = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0);
  endtask

  logic [NO-1:0] lit;
  int rv_at;

  initial begin
    #1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1'b0);
    chk("lit_reset_fc", 256'(frame_count), 256'(0));

    // First frame is discarded, second reports class 0 with count 0.
    rv_seen = 0;
    cyc(1, 0, 0);
    chk("lit_fc_after_first_tick", 256'(frame_count), 256'(1));
    idle(14);
    chk("lit_discard_no_result", 256'(rv_seen), 256'(0));
    cyc(1, 0, 0);
    rv_at = -1;
    for (int i = 1; i <= 13; i++) begin
      cyc(0, 0, 0);
      if (result_valid === 1'b1 && rv_at < 0) rv_at = i;
    end
    chk("lit_result_latency", 256'(rv_at), 256'(11));
    chk("lit_empty_class", 256'(class_out), 256'(0));

    // Indices 30,31,32,200.
    cyc(0, 1, 30); cyc(0, 1, 31); cyc(0, 1, 32); cyc(0, 1, 200);
    cyc(1, 0, 0);
    lit = '0; lit[30] = 1; lit[31] = 1; lit[32] = 1; lit[200] = 1;
    chk("lit_spike_vector", 256'(spike_vector), 256'(lit));
    idle(12);
    chk("lit_class_1", 256'(class_out), 256'(1));
    chk("lit_count_3", 256'(class_count), 256'(3));

    // Duplicates of 5 plus 100,101.
    for (int i = 0; i < 4; i++) cyc(0, 1, 5);
    cyc(0, 1, 100); cyc(0, 1, 101);
    cyc(1, 0, 0);
    idle(12);
    chk("lit_dup_class_4", 256'(class_out), 256'(4));
    chk("lit_dup_count_2", 256'(class_count), 256'(2));

    // Tie between class 0 and class 9.
    cyc(0, 1, 0); cyc(0, 1, 249);
    cyc(1, 0, 0);
    idle(12);
    chk("lit_tie_class_0", 256'(class_out), 256'(0));
    chk("lit_tie_count_1", 256'(class_count), 256'(1));

    // Packet coincident with tick belongs to the new frame.
    cyc(1, 1, 60);
    chk("lit_60_absent", 256'(spike_vector[60]), 256'(0));
    idle(12);
    cyc(1, 0, 0);
    chk("lit_60_present", 256'(spike_vector[60]), 256'(1));
    idle(12);
    chk("lit_60_class_2", 256'(class_out), 256'(2));

    // Out-of-range index and overrun.
    cyc(0, 1, 250);
    chk("lit_range_err", 256'(range_error), 256'(1));
    cyc(0, 1, 120);
    cyc(1, 0, 0);
    idle(2);
    cyc(0, 1, 130); cyc(0, 1, 131);
    rv_seen = 0;
    cyc(1, 0, 0);
    chk("lit_overrun", 256'(overrun_error), 256'(1));
    rv_at = -1;
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 0, 0);
      if (result_valid === 1'b1 && rv_at < 0) rv_at = i;
    end
    chk("lit_overrun_one_result", 256'(rv_seen), 256'(1));
    chk("lit_overrun_latency", 256'(rv_at), 256'(11));
    chk("lit_overrun_class_5", 256'(class_out), 256'(5));
    chk("lit_range_sticky", 256'(range_error), 256'(1));

    // Reset in the middle of a scan suppresses its result.
    cyc(0, 1, 220);
    cyc(1, 0, 0);
    idle(4);
    rv_seen = 0;
    cyc(0, 0, 0, 1'b0);
    idle(14);
    chk("lit_reset_abort", 256'(rv_seen), 256'(0));

    // Randomized traffic with occasional back-to-back ticks.
    for (int i = 0; i < 3000; i++) begin
      bit t, v, r;
      int n;
      t = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 9) < 7);
      n = ($urandom_range(0, 49) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 249);
      r = ($urandom_range(0, 999) != 0);
      cyc(t, v, n, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
